// File: rtl/odo_pkg.sv
// Odo round-key sequencer shared types.
// Widths, period count, FSM states and key entry.
package odo_pkg;

  localparam int KEY_W       = 10;
  localparam int PERIOD_W    = 4;
  localparam int NUM_PERIODS = 9;
  localparam int FIFO_DEPTH  = 3;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0]    key;
    logic [PERIOD_W-1:0] index;
  } rk_entry_t;

endpackage

// File: rtl/odo_round_key_sched_if.sv
// Round-key stream from the sequencer
// to the cipher round datapath.
interface odo_round_key_sched_if;
  import odo_pkg::*;

  logic                rk_valid;
  logic                rk_ready;
  logic [KEY_W-1:0]    rk_key;
  logic [PERIOD_W-1:0] rk_index;
  logic                rk_last;

  modport master (
    output rk_valid,
    output rk_key,
    output rk_index,
    output rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_key,
    input  rk_index,
    input  rk_last,
    output rk_ready
  );

endinterface

// File: rtl/odo_rk_fifo.sv
// Shift-register key buffer: entry 0 is the
// registered head, push+pop legal when full.
module odo_rk_fifo
  import odo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  rk_entry_t        din,
  output rk_entry_t        head,
  output logic [CNT_W-1:0] count
);

  rk_entry_t        mem   [FIFO_DEPTH];
  rk_entry_t        mem_n [FIFO_DEPTH];
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] wr;
  logic             do_pop;
  logic             do_push;

  // Next contents: shift on pop, then write
  // behind the last surviving entry.
  always_comb begin
    do_pop  = pop && (count != '0);
    wr      = count - CNT_W'(do_pop);
    do_push = push && (wr < CNT_W'(FIFO_DEPTH));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_n[i] = mem[i];
    end
    if (do_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        mem_n[i] = mem[i+1];
      end
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (do_push && (wr == CNT_W'(i))) begin
        mem_n[i] = din;
      end
    end
    cnt_n = wr + CNT_W'(do_push);
  end

  // Storage and occupancy; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= cnt_n;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= mem_n[i];
      end
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/odo_round_key_sched.sv
// Walks periods 0..N-1 through the key lookup
// and streams the keys on a valid/ready bus.
module odo_round_key_sched
  import odo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PERIOD_W-1:0]   num_rounds,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [PERIOD_W-1:0]   lk_period,
  input  logic [KEY_W-1:0]      lk_key,
  odo_round_key_sched_if.master rk
);

  state_t              state;
  state_t              state_n;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] n_lat;
  logic [PERIOD_W-1:0] n_clamp;
  logic [PERIOD_W-1:0] issue_idx;
  logic                s1_v;
  logic                s2_v;
  logic [PERIOD_W-1:0] s1_idx;
  logic [PERIOD_W-1:0] s2_idx;
  logic [CNT_W-1:0]    fcount;
  logic [2:0]          occ;
  logic                pop;
  logic                issue;
  logic                flush;
  logic                take;
  rk_entry_t           head;
  rk_entry_t           din;

  assign pop  = rk.rk_valid && rk.rk_ready;
  assign take = (state == IDLE) && start && !abort;

  // Clamp the requested count; entries still
  // owed once this cycle's pop retires.
  always_comb begin
    n_clamp = num_rounds;
    if (num_rounds > PERIOD_W'(NUM_PERIODS)) begin
      n_clamp = PERIOD_W'(NUM_PERIODS);
    end
    occ = 3'(fcount) + 3'(s1_v) + 3'(s2_v) - 3'(pop);
    issue_idx = (state == IDLE) ? '0 : cnt;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and issue decision; period 0
  // goes out on the start edge itself.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    flush   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      flush   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (n_clamp == '0) begin
              state_n = DONE;
            end else begin
              state_n = RUN;
              issue   = 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt >= n_lat) begin
            state_n = DRAIN;
          end else if (occ < 3'(FIFO_DEPTH)) begin
            issue = 1'b1;
          end
        end
        DRAIN: begin
          if (occ == '0) begin
            state_n = DONE;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Issue counter, lookup request and the
  // two-stage in-flight tracking pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      n_lat     <= '0;
      lk_period <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_idx    <= '0;
      s2_idx    <= '0;
    end else begin
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        s1_v   <= issue;
        s2_v   <= s1_v;
        s2_idx <= s1_idx;
      end
      if (issue) begin
        lk_period <= issue_idx;
        s1_idx    <= issue_idx;
        cnt       <= issue_idx + PERIOD_W'(1);
      end
      if (take) begin
        n_lat <= n_clamp;
      end
    end
  end

  assign din.key   = lk_key;
  assign din.index = s2_idx;

  odo_rk_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (s2_v),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (fcount)
  );

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign rk.rk_valid = (fcount != '0);
  assign rk.rk_key   = head.key;
  assign rk.rk_index = head.index;
  assign rk.rk_last  = rk.rk_valid &&
                       (head.index == n_lat - PERIOD_W'(1));

endmodule
